demux_striping_n: RTL and testbench

- Parametrised successor of the two-lane striping demux.
- Distributes a valid-qualified word stream round-robin across up to LANES output lanes in the clk_2f domain.
- Supports runtime-selectable active lane count, a synchronous lane realign, and bundle-complete and bundle-count outputs.
- Sits between the serial-side word source and the per-lane paths (FIFOs or muxes) in the lane-striping datapath.

---
 rtl/demux_striping_n_if.sv | 25 ++
 rtl/demux_striping_n.sv | 53 +++++
 tb/tb_demux_striping_n.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/demux_striping_n_if.sv
// demux_striping_n_if: word-stream input and per-lane output bundle for the striping demux
interface demux_striping_n_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(LANES);
  logic [WIDTH-1:0]       data_in;
  logic                   valid_in;
  logic                   align;
  logic [LW:0]            num_lanes;
  logic [LANES*WIDTH-1:0] data_out;
  logic [LANES-1:0]       valid_out;
  logic [LW-1:0]          lane_ptr;
  logic                   bundle_done;
  logic [CNT_W-1:0]       bundle_cnt;
  modport master (
    output data_in, valid_in, align, num_lanes,
    input  data_out, valid_out, lane_ptr, bundle_done, bundle_cnt
  );
  modport slave (
    input  data_in, valid_in, align, num_lanes,
    output data_out, valid_out, lane_ptr, bundle_done, bundle_cnt
  );
endinterface

// File: rtl/demux_striping_n.sv
// demux_striping_n: round-robin word striping across a runtime-selectable number of lanes
module demux_striping_n #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input logic clk_2f,
  input logic reset_L,
  demux_striping_n_if.slave bus
);
  localparam int LW = $clog2(LANES);
  logic [LANES*WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]       valid_q, valid_d;
  logic [LW-1:0]          ptr_q, ptr_d, p;
  logic [LW:0]            act_q, a, nl;
  logic                   done_q, done_d, last;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  // lane count only takes effect at a bundle boundary or on realign
  always_comb begin
    nl = (bus.num_lanes == '0 || bus.num_lanes > (LW+1)'(LANES)) ? (LW+1)'(LANES) : bus.num_lanes;
    a = (bus.align || ptr_q == '0) ? nl : act_q;
    p = bus.align ? '0 : ptr_q;
    last = {1'b0, p} == a - (LW+1)'(1);
    data_d = data_q;
    if (bus.valid_in) data_d[p*WIDTH +: WIDTH] = bus.data_in;
    valid_d = bus.valid_in ? LANES'(1) << p : '0;
    done_d = bus.valid_in && last;
    ptr_d = !bus.valid_in ? p : last ? '0 : p + LW'(1);
    cnt_d = done_d ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      data_q  <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
      act_q   <= (LW+1)'(LANES);
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      act_q   <= a;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.lane_ptr    = ptr_q;
  assign bus.bundle_done = done_q;
  assign bus.bundle_cnt  = cnt_q;
endmodule

// File: tb/tb_demux_striping_n.sv
// tb_demux_striping_n: directed vector table, corner sequences and randomized run against a lane model
module tb_demux_striping_n;
  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int CNT_W = 8;
  localparam int LW = $clog2(LANES);
  localparam int W = LANES*WIDTH;

  logic clk_2f = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk_2f = ~clk_2f;

  demux_striping_n_if #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) bus ();
  demux_striping_n #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk_2f(clk_2f), .reset_L(reset_L), .bus(bus)
  );

  int n_tests = 0;
  int n_fail = 0;

  int m_ptr, m_act, m_cnt;
  bit m_done;
  int m_vo;
  logic [WIDTH-1:0] m_data [LANES];

  typedef struct {
    bit v;
    int d;
    int lane;
    int vo;
    int ptr;
    bit done;
    int cnt;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_act = LANES; m_cnt = 0; m_done = 0; m_vo = 0;
    for (int k = 0; k < LANES; k++) m_data[k] = '0;
  endtask

  // Word-level view: a word goes to the effective lane; a bundle ends on the last active lane
  task automatic model_step(input bit v, input bit al, input int nl, input logic [WIDTH-1:0] d);
    int req, a, p;
    req = (nl == 0 || nl > LANES) ? LANES : nl;
    a = (al || m_ptr == 0) ? req : m_act;
    p = al ? 0 : m_ptr;
    m_act = a;
    m_done = v && (p == a - 1);
    m_vo = v ? (1 << p) : 0;
    if (v) begin
      m_data[p] = d;
      m_ptr = m_done ? 0 : p + 1;
      if (m_done) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end else m_ptr = p;
  endtask

  task automatic model_check();
    logic [W-1:0] expd;
    for (int k = 0; k < LANES; k++) expd[k*WIDTH +: WIDTH] = m_data[k];
    chk("data_out", bus.data_out, expd);
    chk("valid_out", W'(bus.valid_out), W'(m_vo));
    chk("lane_ptr", W'(bus.lane_ptr), W'(m_ptr));
    chk("bundle_done", W'(bus.bundle_done), W'(m_done));
    chk("bundle_cnt", W'(bus.bundle_cnt), W'(m_cnt));
  endtask

  task automatic cyc(input bit v, input bit al, input int nl, input logic [WIDTH-1:0] d);
    bus.valid_in = v; bus.align = al; bus.num_lanes = (LW+1)'(nl); bus.data_in = d;
    model_step(v, al, nl, d);
    @(posedge clk_2f);
    #1;
    model_check();
  endtask

  initial begin
    int c0;
    bus.valid_in = 0; bus.align = 0; bus.num_lanes = (LW+1)'(4); bus.data_in = '0;
    model_reset();
    repeat (2) @(posedge clk_2f);
    #1;
    model_check();
    chk("reset_valid_out", W'(bus.valid_out), W'(0));
    @(negedge clk_2f);
    reset_L = 1'b1;
    @(posedge clk_2f);
    #1;

    tbl[0]  = '{1, 'hA0, 0, 1, 1, 0, 0};
    tbl[1]  = '{1, 'hA1, 1, 2, 2, 0, 0};
    tbl[2]  = '{1, 'hA2, 2, 4, 3, 0, 0};
    tbl[3]  = '{1, 'hA3, 3, 8, 0, 1, 1};
    tbl[4]  = '{1, 'hA4, 0, 1, 1, 0, 1};
    tbl[5]  = '{1, 'hA5, 1, 2, 2, 0, 1};
    tbl[6]  = '{1, 'hA6, 2, 4, 3, 0, 1};
    tbl[7]  = '{1, 'hA7, 3, 8, 0, 1, 2};
    tbl[8]  = '{1, 'h10, 0, 1, 1, 0, 2};
    tbl[9]  = '{0, 'h00, -1, 0, 1, 0, 2};
    tbl[10] = '{1, 'h11, 1, 2, 2, 0, 2};
    tbl[11] = '{0, 'h00, -1, 0, 2, 0, 2};
    tbl[12] = '{0, 'h00, -1, 0, 2, 0, 2};
    tbl[13] = '{1, 'h12, 2, 4, 3, 0, 2};
    tbl[14] = '{0, 'h00, -1, 0, 3, 0, 2};
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].v, 0, 4, WIDTH'(tbl[i].d));
      chk("tbl_valid_out", W'(bus.valid_out), W'(tbl[i].vo));
      chk("tbl_lane_ptr", W'(bus.lane_ptr), W'(tbl[i].ptr));
      chk("tbl_bundle_done", W'(bus.bundle_done), W'(tbl[i].done));
      chk("tbl_bundle_cnt", W'(bus.bundle_cnt), W'(tbl[i].cnt));
      if (tbl[i].lane >= 0)
        chk("tbl_lane_data", W'(bus.data_out[tbl[i].lane*WIDTH +: WIDTH]), W'(tbl[i].d));
    end

    // asynchronous reset between edges with lane_ptr at 3
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    model_check();
    #2 reset_L = 1'b1;
    cyc(1, 0, 4, 'h77);
    chk("post_reset_lane0", W'(bus.data_out[0 +: WIDTH]), W'('h77));
    chk("post_reset_valid", W'(bus.valid_out), W'(1));

    cyc(1, 0, 4, 'h78);
    c0 = m_cnt;
    cyc(1, 1, 4, 'h55);
    chk("align_lane0", W'(bus.data_out[0 +: WIDTH]), W'('h55));
    chk("align_ptr", W'(bus.lane_ptr), W'(1));
    chk("align_done", W'(bus.bundle_done), W'(0));
    chk("align_cnt", W'(bus.bundle_cnt), W'(c0));
    repeat (3) cyc(1, 0, 4, $urandom);

    cyc(1, 0, 4, 'h20);
    cyc(1, 0, 4, 'h21);
    cyc(1, 0, 2, 'h22);
    chk("switch_lane2", W'(bus.valid_out), W'(4));
    cyc(1, 0, 2, 'h23);
    chk("switch_lane3", W'(bus.valid_out), W'(8));
    chk("switch_done4", W'(bus.bundle_done), W'(1));
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 2, WIDTH'('h30 + i));
      chk("two_lane_valid", W'(bus.valid_out), W'(1 << (i % 2)));
      chk("two_lane_done", W'(bus.bundle_done), W'(i % 2));
    end

    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++) begin
        cyc(1, 0, j == 0 ? 0 : 7, $urandom);
        chk("clamp_valid", W'(bus.valid_out), W'(1 << i));
        chk("clamp_done", W'(bus.bundle_done), W'(i == 3));
      end

    for (int i = 0; i < 300 && m_cnt != 255; i++) begin
      cyc(1, 0, 1, WIDTH'(i));
      chk("one_lane_valid", W'(bus.valid_out), W'(1));
    end
    chk("cnt_ff", W'(bus.bundle_cnt), W'('hFF));
    cyc(1, 0, 1, 'hAB);
    chk("cnt_wrap", W'(bus.bundle_cnt), W'(0));
    chk("wrap_done", W'(bus.bundle_done), W'(1));

    for (int i = 0; i < 500; i++)
      cyc($urandom_range(3, 0) != 0, $urandom_range(9, 0) == 0, int'($urandom_range(7, 0)), $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
